dfm_result_tx: RTL

Serial result transmitter for the frequency meter, downstream of the top-level sequencing controller. On a start pulse it latches the frequency and period measurement results and the active mode, and frames them as 8N1 UART bytes on `txd`. It holds `Cbusy` high for the whole frame so the controller can wait for completion before returning to Ready.

---
 rtl/dfm_pkg.sv | 31 +++
 rtl/dfm_uart_tx_byte.sv | 60 ++++++
 rtl/dfm_result_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dfm_pkg.sv
// Shared definitions for the frequency-meter result transmitter.
// Build option: DFM_RESULT_TX_CHECKSUM_EN appends an XOR checksum byte to each frame.
package dfm_pkg;

  localparam logic [7:0] TX_HEADER = 8'hA5;

`ifdef DFM_RESULT_TX_CHECKSUM_EN
  localparam int TX_FRAME_LEN = 11;
`else
  localparam int TX_FRAME_LEN = 10;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    NEXT = 2'd3
  } tx_state_t;

  // Mode encoding shared with the sequencing controller.
  typedef enum logic [1:0] {
    MODE_NONE   = 2'b00,
    MODE_PERIOD = 2'b01,
    MODE_FREQ   = 2'b10,
    MODE_BOTH   = 2'b11
  } dfm_mode_t;

  localparam int MODE_FREQ_BIT   = 1;
  localparam int MODE_PERIOD_BIT = 0;

endpackage

// File: rtl/dfm_uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
// byte_done is raised one cycle before the stop bit ends so the framer's
// NEXT/LOAD handoff overlaps the tail of the stop bit; the next start bit
// then follows the stop bit after exactly two idle-level cycles.
module dfm_uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       txd,
  output logic       byte_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit_idx;
  logic [8:0]    r_shift;
  logic          r_txd;

  // Load a byte when idle, then step through the ten bit slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_bit_idx <= 4'd0;
      r_shift   <= 9'h1FF;
      r_txd     <= 1'b1;
    end else if (!r_busy) begin
      if (byte_valid) begin
        r_busy    <= 1'b1;
        r_cnt     <= '0;
        r_bit_idx <= 4'd0;
        r_shift   <= {1'b1, byte_data};
        r_txd     <= 1'b0;
      end
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      if (r_bit_idx == 4'd9) begin
        r_busy <= 1'b0;
        r_txd  <= 1'b1;
      end else begin
        r_txd     <= r_shift[0];
        r_shift   <= {1'b1, r_shift[8:1]};
        r_bit_idx <= r_bit_idx + 4'd1;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign txd       = r_txd;
  assign byte_done = r_busy && (r_bit_idx == 4'd9) && (r_cnt == CNT_PRE);

endmodule

// File: rtl/dfm_result_tx.sv
// Result framer: latches mode/fcount/tcount on a start request and sends
// A5, mode, fcount (MSB first), tcount (MSB first) as 8N1 bytes.
// Build option: DFM_RESULT_TX_CHECKSUM_EN adds an XOR checksum of bytes 1..9.
module dfm_result_tx
  import dfm_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Cstart,
  output logic        Cbusy,
  input  logic [1:0]  mode,
  input  logic [31:0] fcount,
  input  logic [31:0] tcount,
  output logic        txd
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [3:0] LAST_IDX = 4'(TX_FRAME_LEN - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_baud_check
      $error("dfm_result_tx: CLK_HZ/BAUD must be at least 2");
    end
  endgenerate

  tx_state_t   r_state;
  tx_state_t   w_state_next;
  logic        r_armed;
  logic        r_cbusy;
  logic [3:0]  r_idx;
  logic [1:0]  r_mode;
  logic [31:0] r_fcount;
  logic [31:0] r_tcount;
  logic        r_byte_valid;
  logic [7:0]  r_byte_data;
  logic [7:0]  w_byte_sel;
  logic        w_accept;
  logic        w_byte_done;
  logic        w_txd;
`ifdef DFM_RESULT_TX_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  // A level-held request starts only one frame; it must drop before re-arming.
  assign w_accept = (r_state == IDLE) && Cstart && r_armed;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = LOAD;
      LOAD:    w_state_next = SEND;
      SEND:    if (w_byte_done) w_state_next = NEXT;
      NEXT:    w_state_next = (r_idx < LAST_IDX) ? LOAD : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Arming flag, registered busy flag and byte index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b1;
      r_cbusy <= 1'b0;
      r_idx   <= 4'd0;
    end else begin
      if (w_accept)     r_armed <= 1'b0;
      else if (!Cstart) r_armed <= 1'b1;
      r_cbusy <= (w_state_next != IDLE);
      if (w_accept)
        r_idx <= 4'd0;
      else if ((r_state == NEXT) && (r_idx < LAST_IDX))
        r_idx <= r_idx + 4'd1;
    end
  end

  // Shadow registers; a field whose mode bit is clear is sent as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode   <= 2'b00;
      r_fcount <= 32'h0;
      r_tcount <= 32'h0;
    end else if (w_accept) begin
      r_mode   <= mode;
      r_fcount <= mode[MODE_FREQ_BIT]   ? fcount : 32'h0;
      r_tcount <= mode[MODE_PERIOD_BIT] ? tcount : 32'h0;
    end
  end

  // Byte selection by frame position.
  always_comb begin
    w_byte_sel = 8'h00;
    case (r_idx)
      4'd0:    w_byte_sel = TX_HEADER;
      4'd1:    w_byte_sel = {6'b000000, r_mode};
      4'd2:    w_byte_sel = r_fcount[31:24];
      4'd3:    w_byte_sel = r_fcount[23:16];
      4'd4:    w_byte_sel = r_fcount[15:8];
      4'd5:    w_byte_sel = r_fcount[7:0];
      4'd6:    w_byte_sel = r_tcount[31:24];
      4'd7:    w_byte_sel = r_tcount[23:16];
      4'd8:    w_byte_sel = r_tcount[15:8];
      4'd9:    w_byte_sel = r_tcount[7:0];
`ifdef DFM_RESULT_TX_CHECKSUM_EN
      4'd10:   w_byte_sel = r_csum;
`endif
      default: w_byte_sel = 8'h00;
    endcase
  end

  // Hand the selected byte to the serializer one cycle after LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_valid <= 1'b0;
      r_byte_data  <= 8'h00;
    end else begin
      r_byte_valid <= (r_state == LOAD);
      if (r_state == LOAD) r_byte_data <= w_byte_sel;
    end
  end

`ifdef DFM_RESULT_TX_CHECKSUM_EN
  // Running XOR of bytes 1..9 (header excluded), ready by the time idx reaches 10.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_csum <= 8'h00;
    else if (w_accept)
      r_csum <= 8'h00;
    else if ((r_state == LOAD) && (r_idx != 4'd0) && (r_idx <= 4'd9))
      r_csum <= r_csum ^ w_byte_sel;
  end
`endif

  dfm_uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (r_byte_valid),
    .byte_data  (r_byte_data),
    .txd        (w_txd),
    .byte_done  (w_byte_done)
  );

  assign txd   = w_txd;
  assign Cbusy = r_cbusy;

endmodule
